// File: rtl/letc_core_pkg.sv
// Shared types and constants for the LETC core fetch path.
package letc_core_pkg;

    typedef logic [29:0] pc_word_t;

    typedef struct packed {
        logic      valid;
        pc_word_t  pc_word;
        logic [31:0] fetch_addr;
    } f1_to_f2_s;

    localparam pc_word_t RESET_PC_WORD_DEFAULT = 30'h0;

    function automatic logic [31:0] word_to_byte(input pc_word_t word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/letc_core_f1_next_pc.sv
// F1 fetch target selection: trap > branch > pending redirect > current pc, plus the +1 successor.
module letc_core_f1_next_pc
    import letc_core_pkg::*;
(
    input  logic     trap_valid,
    input  pc_word_t trap_pc_word,
    input  logic     branch_valid,
    input  pc_word_t branch_pc_word,
    input  logic     pend_valid,
    input  pc_word_t pend_pc_word,
    input  pc_word_t pc_word,
    output logic     redirect_any,
    output pc_word_t redirect_target,
    output pc_word_t sel_pc_word,
    output pc_word_t sel_pc_word_inc
);

    always_comb begin
        redirect_any    = trap_valid | branch_valid;
        redirect_target = trap_valid ? trap_pc_word : branch_pc_word;
        if (redirect_any)
            sel_pc_word = redirect_target;
        else if (pend_valid)
            sel_pc_word = pend_pc_word;
        else
            sel_pc_word = pc_word;
        // 30-bit add wraps 3FFFFFFF -> 0 naturally
        sel_pc_word_inc = sel_pc_word + 30'd1;
    end

endmodule

// File: rtl/letc_core_stage_f1.sv
// LETC core F1: owns the fetch PC and issues one registered word-aligned fetch per cycle to F2.
// Optional fetch counter port o_fetch_count is built when LETC_CORE_F1_PERF_CNT_EN is defined.
//
// state          | meaning
// F1_IDLE        | no fetch issued; waiting for i_fetch_en
// F1_RUN         | one fetch issued per unstalled cycle
// F1_REDIR_PEND  | redirect arrived while stalled; target held in pend_pc_word
module letc_core_stage_f1
    import letc_core_pkg::*;
#(
    parameter pc_word_t RESET_PC_WORD = RESET_PC_WORD_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_en,
    output logic        o_stage_ready,
    input  logic        i_stage_flush,
    input  logic        i_stage_stall,
    input  logic        i_redirect_valid,
    input  logic [29:0] i_redirect_pc_word,
    input  logic        i_trap_valid,
    input  logic [29:0] i_trap_pc_word,
    output f1_to_f2_s   o_f1_to_f2
`ifdef LETC_CORE_F1_PERF_CNT_EN
    ,
    output logic [31:0] o_fetch_count
`endif
);

    typedef enum logic [1:0] {
        F1_IDLE       = 2'd0,
        F1_RUN        = 2'd1,
        F1_REDIR_PEND = 2'd2
    } f1_state_e;

    f1_state_e state;
    pc_word_t  pc_word;
    pc_word_t  pend_pc_word;
    logic      pend_valid;
    logic      redirect_any;
    pc_word_t  redirect_target;
    pc_word_t  sel_pc_word;
    pc_word_t  sel_pc_word_inc;
    logic      fetch_fire;

    assign pend_valid = (state == F1_REDIR_PEND);

    letc_core_f1_next_pc u_next_pc (
        .trap_valid      (i_trap_valid),
        .trap_pc_word    (i_trap_pc_word),
        .branch_valid    (i_redirect_valid),
        .branch_pc_word  (i_redirect_pc_word),
        .pend_valid      (pend_valid),
        .pend_pc_word    (pend_pc_word),
        .pc_word         (pc_word),
        .redirect_any    (redirect_any),
        .redirect_target (redirect_target),
        .sel_pc_word     (sel_pc_word),
        .sel_pc_word_inc (sel_pc_word_inc)
    );

    assign fetch_fire = !i_stage_flush && !i_stage_stall && i_fetch_en &&
                        ((state == F1_RUN) || (state == F1_REDIR_PEND));

    assign o_stage_ready = (state == F1_RUN) && !i_stage_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= F1_IDLE;
            pc_word      <= RESET_PC_WORD;
            pend_pc_word <= '0;
            o_f1_to_f2   <= '0;
        end else if (i_stage_flush) begin
            // Kill this cycle's fetch; any redirect or pending target lands in pc for a 1-bubble restart
            o_f1_to_f2.valid <= 1'b0;
            pc_word          <= sel_pc_word;
            pend_pc_word     <= '0;
            state            <= i_fetch_en ? F1_RUN : F1_IDLE;
        end else if (i_stage_stall) begin
            if (redirect_any) begin
                pend_pc_word <= redirect_target;
                state        <= F1_REDIR_PEND;
            end
        end else begin
            case (state)
                F1_IDLE: begin
                    o_f1_to_f2.valid <= 1'b0;
                    pc_word          <= sel_pc_word;
                    if (i_fetch_en)
                        state <= F1_RUN;
                end
                F1_RUN, F1_REDIR_PEND: begin
                    pend_pc_word <= '0;
                    if (i_fetch_en) begin
                        o_f1_to_f2 <= '{valid: 1'b1, pc_word: sel_pc_word,
                                        fetch_addr: word_to_byte(sel_pc_word)};
                        pc_word    <= sel_pc_word_inc;
                        state      <= F1_RUN;
                    end else begin
                        o_f1_to_f2.valid <= 1'b0;
                        pc_word          <= sel_pc_word;
                        state            <= F1_IDLE;
                    end
                end
                default: state <= F1_IDLE;
            endcase
        end
    end

`ifdef LETC_CORE_F1_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_fetch_count <= '0;
        else if (fetch_fire)
            o_fetch_count <= o_fetch_count + 32'd1;
    end
`endif

    // Hazard control never flushes and stalls the same cycle
    flush_stall_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_stage_flush && i_stage_stall));

endmodule

// File: tb/tb_letc_core_stage_f1.sv
// Directed self-checking bench for letc_core_stage_f1 (default and wrap-around reset PC instances).
module tb_letc_core_stage_f1;
    import letc_core_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_fetch_en;
    logic        i_stage_flush;
    logic        i_stage_stall;
    logic        i_redirect_valid;
    logic [29:0] i_redirect_pc_word;
    logic        i_trap_valid;
    logic [29:0] i_trap_pc_word;
    logic        ready, ready_w;
    f1_to_f2_s   out, out_w;
`ifdef LETC_CORE_F1_PERF_CNT_EN
    logic [31:0] fetch_count, fetch_count_w;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    letc_core_stage_f1 dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_fetch_en         (i_fetch_en),
        .o_stage_ready      (ready),
        .i_stage_flush      (i_stage_flush),
        .i_stage_stall      (i_stage_stall),
        .i_redirect_valid   (i_redirect_valid),
        .i_redirect_pc_word (i_redirect_pc_word),
        .i_trap_valid       (i_trap_valid),
        .i_trap_pc_word     (i_trap_pc_word),
        .o_f1_to_f2         (out)
`ifdef LETC_CORE_F1_PERF_CNT_EN
        ,
        .o_fetch_count      (fetch_count)
`endif
    );

    letc_core_stage_f1 #(.RESET_PC_WORD(30'h3FFFFFFE)) dut_wrap (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_fetch_en         (i_fetch_en),
        .o_stage_ready      (ready_w),
        .i_stage_flush      (i_stage_flush),
        .i_stage_stall      (i_stage_stall),
        .i_redirect_valid   (i_redirect_valid),
        .i_redirect_pc_word (i_redirect_pc_word),
        .i_trap_valid       (i_trap_valid),
        .i_trap_pc_word     (i_trap_pc_word),
        .o_f1_to_f2         (out_w)
`ifdef LETC_CORE_F1_PERF_CNT_EN
        ,
        .o_fetch_count      (fetch_count_w)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [29:0] exp_pc);
        chk({tag, "_valid"}, 32'(out.valid), 32'd1);
        chk({tag, "_pc"}, 32'(out.pc_word), 32'(exp_pc));
        chk({tag, "_addr"}, out.fetch_addr, {exp_pc, 2'b00});
    endtask

    logic [29:0] wrap_exp [3];

    initial begin
        wrap_exp[0] = 30'h3FFFFFFE;
        wrap_exp[1] = 30'h3FFFFFFF;
        wrap_exp[2] = 30'h0;

        i_rst_n = 1'b0;
        i_fetch_en = 1'b0;
        i_stage_flush = 1'b0;
        i_stage_stall = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc_word = '0;
        i_trap_valid = 1'b0;
        i_trap_pc_word = '0;
        #2;
        chk("rst_valid", 32'(out.valid), 32'd0);
        chk("rst_pc", 32'(out.pc_word), 32'd0);
        chk("rst_addr", out.fetch_addr, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
`ifdef LETC_CORE_F1_PERF_CNT_EN
        chk("rst_count", fetch_count, 32'd0);
`endif

        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_fetch_en = 1'b1;
        step();
        chk("first_bubble", 32'(out.valid), 32'd0);
        chk("run_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("seq", 30'(i));
            if (i < 3) begin
                chk("wrap_pc", 32'(out_w.pc_word), 32'(wrap_exp[i]));
                chk("wrap_addr", out_w.fetch_addr, {wrap_exp[i], 2'b00});
            end
        end
        step();
        step();
        chk_out("at5", 30'h5);

        i_redirect_valid = 1'b1;
        i_redirect_pc_word = 30'h100;
        step();
        i_redirect_valid = 1'b0;
        chk_out("br0", 30'h100);
        step();
        chk_out("br1", 30'h101);

        i_trap_valid = 1'b1;
        i_trap_pc_word = 30'h40;
        i_redirect_valid = 1'b1;
        i_redirect_pc_word = 30'h100;
        i_stage_flush = 1'b1;
        step();
        i_trap_valid = 1'b0;
        i_redirect_valid = 1'b0;
        i_stage_flush = 1'b0;
        chk("flush_bubble", 32'(out.valid), 32'd0);
        step();
        chk_out("trap0", 30'h40);
        step();
        chk_out("trap1", 30'h41);

        i_stage_stall = 1'b1;
        #1;
        chk("stall_ready", 32'(ready), 32'd0);
        step();
        chk_out("stall1", 30'h41);
        i_redirect_valid = 1'b1;
        i_redirect_pc_word = 30'h20;
        step();
        i_redirect_valid = 1'b0;
        chk_out("stall2", 30'h41);
        chk("stall2_ready", 32'(ready), 32'd0);
        step();
        chk_out("stall3", 30'h41);
        i_stage_stall = 1'b0;
        step();
        chk_out("pend0", 30'h20);
        step();
        chk_out("pend1", 30'h21);

        i_fetch_en = 1'b0;
        step();
        chk("dis_valid0", 32'(out.valid), 32'd0);
        step();
        chk("dis_valid1", 32'(out.valid), 32'd0);
        chk("dis_ready", 32'(ready), 32'd0);
        i_fetch_en = 1'b1;
        step();
        chk("reen_bubble", 32'(out.valid), 32'd0);
        step();
        chk_out("resume", 30'h22);

        i_stage_stall = 1'b1;
        i_redirect_valid = 1'b1;
        i_redirect_pc_word = 30'h50;
        step();
        i_stage_stall = 1'b0;
        i_redirect_pc_word = 30'h60;
        step();
        i_redirect_valid = 1'b0;
        chk_out("newest0", 30'h60);
        step();
        chk_out("newest1", 30'h61);

        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        step();
        chk("perf_bubble", 32'(out.valid), 32'd0);
        repeat (4) step();
        chk_out("perf_a", 30'h3);
        i_stage_stall = 1'b1;
        repeat (2) step();
        i_stage_stall = 1'b0;
        i_stage_flush = 1'b1;
        step();
        i_stage_flush = 1'b0;
        chk("perf_flush", 32'(out.valid), 32'd0);
        repeat (6) step();
        chk_out("perf_b", 30'h9);
`ifdef LETC_CORE_F1_PERF_CNT_EN
        chk("perf_count", fetch_count, 32'd10);
`endif
        i_stage_stall = 1'b1;
        step();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out.valid), 32'd0);
        chk("mid_rst_pc", 32'(out.pc_word), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
`ifdef LETC_CORE_F1_PERF_CNT_EN
        chk("mid_rst_count", fetch_count, 32'd0);
`endif
        i_stage_stall = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
